// File: rtl/decode_operand_stage_pkg.sv
// rtl/decode_operand_stage_pkg.sv - shared widths, CTRL bundle field offsets and register-match helper
package decode_operand_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Field offsets inside the opaque EX control bundle; this stage only passes it through.
  localparam int CTRL_ALU_OP_LSB    = 0;
  localparam int CTRL_ALU_OP_W      = 4;
  localparam int CTRL_BRANCH_BIT    = 4;
  localparam int CTRL_JUMP_BIT      = 5;
  localparam int CTRL_SRC_IMM_BIT   = 6;
  localparam int CTRL_MEM_WRITE_BIT = 7;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_MEM,
    SEL_WB,
    SEL_RF
  } operand_sel_e;

  // x0 never matches a producer, so it can never cause a forward or a stall.
  function automatic logic src_hit(input reg_addr_t rs, input reg_addr_t waddr);
    return (rs != REG_ZERO) && (rs == waddr);
  endfunction

endpackage

// File: rtl/decode_operand_stage_operand_bypass.sv
// rtl/decode_operand_stage_operand_bypass.sv - per-source operand select chain
// DECODE_STAGE_WB_BYPASS_EN adds the same-cycle WB forward.
module operand_bypass
  import decode_operand_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  reg_addr_t       rs,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic            mem_we,
  input  logic            mem_is_load,
  input  reg_addr_t       mem_waddr,
  input  logic [XLEN-1:0] mem_wdata,
`ifdef DECODE_STAGE_WB_BYPASS_EN
  input  logic            wb_we,
  input  reg_addr_t       wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
`endif
  output logic [XLEN-1:0] operand
);

  operand_sel_e sel;

  always_comb begin
    sel = SEL_RF;
    if (rs == REG_ZERO)
      sel = SEL_ZERO;
    else if (mem_we && !mem_is_load && (mem_waddr == rs))
      sel = SEL_MEM;
`ifdef DECODE_STAGE_WB_BYPASS_EN
    else if (wb_we && (wb_waddr == rs))
      sel = SEL_WB;
`endif
  end

  always_comb begin
    operand = rf_rdata;
    case (sel)
      SEL_ZERO: operand = '0;
      SEL_MEM:  operand = mem_wdata;
`ifdef DECODE_STAGE_WB_BYPASS_EN
      SEL_WB:   operand = wb_wdata;
`endif
      default:  operand = rf_rdata;
    endcase
  end

endmodule

// File: rtl/decode_operand_stage.sv
// rtl/decode_operand_stage.sv - operand fetch, RAW hazard resolution and ID/EX register
// DECODE_STAGE_WB_BYPASS_EN: forward WB writes instead of stalling on them.
module decode_operand_stage
  import decode_operand_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  reg_addr_t         in_rs1,
  input  reg_addr_t         in_rs2,
  input  reg_addr_t         in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  output reg_addr_t         rf_raddr1,
  output reg_addr_t         rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              mem_we,
  input  logic              mem_is_load,
  input  reg_addr_t         mem_waddr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              wb_we,
  input  reg_addr_t         wb_waddr,
  input  logic [XLEN-1:0]   wb_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output reg_addr_t         out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic            advance;
  logic            hazard;
  logic            haz_ex;
  logic            haz_load;
  logic            haz_wb;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  assign advance = !out_valid || out_ready;

  // There is no EX-stage forward path, so any writer still in ID/EX forces a bubble.
  assign haz_ex   = out_valid && out_reg_write &&
                    (src_hit(in_rs1, out_rd) || src_hit(in_rs2, out_rd));
  assign haz_load = mem_we && mem_is_load &&
                    (src_hit(in_rs1, mem_waddr) || src_hit(in_rs2, mem_waddr));

`ifdef DECODE_STAGE_WB_BYPASS_EN
  assign haz_wb = 1'b0;
`else
  logic unused_wb_wdata;
  assign unused_wb_wdata = ^wb_wdata;
  // Without the WB forward, wait one cycle for the register file to hold the new value.
  assign haz_wb = wb_we && (src_hit(in_rs1, wb_waddr) || src_hit(in_rs2, wb_waddr));
`endif

  assign hazard   = haz_ex || haz_load || haz_wb;
  assign in_ready = advance && !hazard && !flush;

  operand_bypass #(.XLEN(XLEN)) u_bypass1 (
    .rs          (in_rs1),
    .rf_rdata    (rf_rdata1),
    .mem_we      (mem_we),
    .mem_is_load (mem_is_load),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
`ifdef DECODE_STAGE_WB_BYPASS_EN
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
`endif
    .operand     (op1)
  );

  operand_bypass #(.XLEN(XLEN)) u_bypass2 (
    .rs          (in_rs2),
    .rf_rdata    (rf_rdata2),
    .mem_we      (mem_we),
    .mem_is_load (mem_is_load),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
`ifdef DECODE_STAGE_WB_BYPASS_EN
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
`endif
    .operand     (op2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_op1       <= '0;
      out_op2       <= '0;
      out_rd        <= REG_ZERO;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_imm       <= '0;
      out_pc        <= '0;
      out_ctrl      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance && hazard && in_valid) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_op1       <= op1;
        out_op2       <= op2;
        out_rd        <= in_rd;
        out_reg_write <= in_reg_write;
        out_mem_read  <= in_mem_read;
        out_imm       <= in_imm;
        out_pc        <= in_pc;
        out_ctrl      <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (in_valid && !in_ready && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// tb/tb_decode_operand_stage.sv - directed self-checking bench for decode_operand_stage
// Expectations follow DECODE_STAGE_WB_BYPASS_EN when the bench is built with it.
module tb_decode_operand_stage;

  localparam int XLEN      = 32;
  localparam int CTRL_W    = 8;
  localparam int CNT_W     = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic              in_reg_write, in_mem_read;
  logic [XLEN-1:0]   in_imm, in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic              mem_we, mem_is_load;
  logic [4:0]        mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic              wb_we;
  logic [4:0]        wb_waddr;
  logic [XLEN-1:0]   wb_wdata;
  logic              flush;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_op1, out_op2;
  logic [4:0]        out_rd;
  logic              out_reg_write, out_mem_read;
  logic [XLEN-1:0]   out_imm, out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cycles;

  int vectors;
  int miscompares;
  int exp_stall;

  logic [XLEN-1:0] rf_mem [32];

  decode_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_imm(out_imm), .out_pc(out_pc), .out_ctrl(out_ctrl),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-before-write register file model driven by the WB port.
  always @(posedge clk) if (wb_we && wb_waddr != 5'd0) rf_mem[wb_waddr] <= wb_wdata;
  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? '0 : rf_mem[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? '0 : rf_mem[rf_raddr2];

  function automatic logic [CNT_W-1:0] sat(input int v);
    return (v > STALL_MAX) ? CNT_W'(STALL_MAX) : CNT_W'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_reg_write = 0; in_mem_read = 0; in_imm = 0; in_pc = 0; in_ctrl = 0;
    mem_we = 0; mem_is_load = 0; mem_waddr = 0; mem_wdata = 0;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic [XLEN-1:0] imm,
                       input logic [XLEN-1:0] pc, input logic [CTRL_W-1:0] ctrl);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_reg_write = rw; in_mem_read = mr; in_imm = imm; in_pc = pc; in_ctrl = ctrl;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [XLEN-1:0] d);
    in_valid = 0; wb_we = 1; wb_waddr = a; wb_wdata = d;
    step();
    wb_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h77, 32'h100, 8'h5A);
    step(); step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    vectors++; if (stall_cycles !== '0) begin miscompares++; $display("FAIL reset stall_cycles: got %0d want 0", stall_cycles); end
    vectors++; if ({out_pc, out_op1} !== 64'h0) begin miscompares++; $display("FAIL reset payload: got %h want 0", {out_pc, out_op1}); end
    rst = 0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    step();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL first out_valid: got %b want 1", out_valid); end
    vectors++; if ({out_pc, out_imm, out_rd, out_reg_write, out_ctrl} !== {32'h100, 32'h77, 5'd3, 1'b1, 8'h5A})
      begin miscompares++; $display("FAIL first payload: got %h want %h", {out_pc, out_imm, out_rd, out_reg_write, out_ctrl}, {32'h100, 32'h77, 5'd3, 1'b1, 8'h5A}); end
    in_valid = 0;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_mem_over_wb();
    idle(); rf_write(5'd5, 32'h11);
    issue(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h110, 8'h0);
    mem_we = 1; mem_waddr = 5; mem_wdata = 32'hAA;
    wb_we = 1; wb_waddr = 5; wb_wdata = 32'hBB;
    #1;
    vectors++; if (rf_raddr1 !== 5'd5) begin miscompares++; $display("FAIL rf_raddr1: got %0d want 5", rf_raddr1); end
`ifndef DECODE_STAGE_WB_BYPASS_EN
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mem_over_wb wb stall: got %b want 0", in_ready); end
    step(); exp_stall++;
    wb_we = 0; #1;
`endif
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mem_over_wb in_ready: got %b want 1", in_ready); end
    step();
    vectors++; if ({out_valid, out_op1, out_op2} !== {1'b1, 32'hAA, 32'h0})
      begin miscompares++; $display("FAIL mem_over_wb operands: got %h want %h", {out_valid, out_op1, out_op2}, {1'b1, 32'hAA, 32'h0}); end
    idle(); step();
  endtask

  task automatic test_load_use();
    idle();
    issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h0, 32'h120, 8'h0);
    step();
    vectors++; if ({out_valid, out_mem_read} !== 2'b11) begin miscompares++; $display("FAIL load captured: got %b want 11", {out_valid, out_mem_read}); end
    issue(5'd0, 5'd7, 5'd8, 1'b0, 1'b0, 32'h0, 32'h124, 8'h0);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL load_use ex hazard: got %b want 0", in_ready); end
    step(); exp_stall++;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL load_use bubble1: got %b want 0", out_valid); end
    mem_we = 1; mem_is_load = 1; mem_waddr = 7; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL load_use mem hazard: got %b want 0", in_ready); end
    step(); exp_stall++;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL load_use bubble2: got %b want 0", out_valid); end
    mem_we = 0; mem_is_load = 0; wb_we = 1; wb_waddr = 7; wb_wdata = 32'hCAFE; #1;
`ifndef DECODE_STAGE_WB_BYPASS_EN
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL load_use wb stall: got %b want 0", in_ready); end
    step(); exp_stall++;
    wb_we = 0; #1;
`endif
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL load_use release: got %b want 1", in_ready); end
    step();
    vectors++; if ({out_valid, out_op2, out_pc} !== {1'b1, 32'hCAFE, 32'h124})
      begin miscompares++; $display("FAIL load_use data: got %h want %h", {out_valid, out_op2, out_pc}, {1'b1, 32'hCAFE, 32'h124}); end
    vectors++; if (stall_cycles !== sat(exp_stall)) begin miscompares++; $display("FAIL load_use stall_cycles: got %0d want %0d", stall_cycles, sat(exp_stall)); end
    idle(); step();
  endtask

  task automatic test_x0();
    idle();
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h130, 8'h0);
    mem_we = 1; mem_waddr = 0; mem_wdata = 32'h55; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL x0 in_ready: got %b want 1", in_ready); end
    step();
    vectors++; if (out_op1 !== 32'h0) begin miscompares++; $display("FAIL x0 op1: got %h want 0", out_op1); end
    mem_is_load = 1; wb_we = 1; wb_waddr = 0; wb_wdata = 32'h66; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL x0 load/wb/ex in_ready: got %b want 1", in_ready); end
    step();
    vectors++; if ({out_op1, out_op2} !== 64'h0) begin miscompares++; $display("FAIL x0 operands: got %h want 0", {out_op1, out_op2}); end
    vectors++; if (stall_cycles !== sat(exp_stall)) begin miscompares++; $display("FAIL x0 stall_cycles: got %0d want %0d", stall_cycles, sat(exp_stall)); end
    idle(); step();
  endtask

  task automatic test_hold_flush();
    idle();
    issue(5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 32'hDEAD, 32'h300, 8'h3C);
    step();
    out_ready = 0;
    issue(5'd0, 5'd0, 5'd13, 1'b0, 1'b0, 32'hBEEF, 32'h304, 8'h11);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold in_ready[%0d]: got %b want 0", i, in_ready); end
      step(); exp_stall++;
      vectors++; if ({out_valid, out_pc, out_imm, out_ctrl} !== {1'b1, 32'h300, 32'hDEAD, 8'h3C})
        begin miscompares++; $display("FAIL hold stable[%0d]: got %h want %h", i, {out_valid, out_pc, out_imm, out_ctrl}, {1'b1, 32'h300, 32'hDEAD, 8'h3C}); end
    end
    flush = 1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush in_ready: got %b want 0", in_ready); end
    step(); exp_stall++;
    vectors++; if ({out_valid, out_pc} !== {1'b0, 32'h300}) begin miscompares++; $display("FAIL flush: got %h want %h", {out_valid, out_pc}, {1'b0, 32'h300}); end
    vectors++; if (stall_cycles !== sat(exp_stall)) begin miscompares++; $display("FAIL hold stall_cycles: got %0d want %0d", stall_cycles, sat(exp_stall)); end
    idle(); step();
  endtask

  task automatic test_wb_forward();
    idle(); rf_write(5'd9, 32'h999);
    issue(5'd9, 5'd0, 5'd14, 1'b0, 1'b0, 32'h0, 32'h400, 8'h0);
    wb_we = 1; wb_waddr = 9; wb_wdata = 32'h1234; #1;
`ifdef DECODE_STAGE_WB_BYPASS_EN
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL wb bypass in_ready: got %b want 1", in_ready); end
    step();
`else
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL wb stall in_ready: got %b want 0", in_ready); end
    step(); exp_stall++;
    wb_we = 0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL wb release in_ready: got %b want 1", in_ready); end
    step();
`endif
    vectors++; if ({out_valid, out_op1} !== {1'b1, 32'h1234}) begin miscompares++; $display("FAIL wb op1: got %h want %h", {out_valid, out_op1}, {1'b1, 32'h1234}); end
    vectors++; if (stall_cycles !== sat(exp_stall)) begin miscompares++; $display("FAIL wb stall_cycles: got %0d want %0d", stall_cycles, sat(exp_stall)); end
    idle(); step();
  endtask

  task automatic test_back_to_back();
    idle(); rf_write(5'd3, 32'h33); rf_write(5'd4, 32'h44);
    issue(5'd3, 5'd0, 5'd10, 1'b1, 1'b0, 32'h0, 32'h500, 8'h0); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b first in_ready: got %b want 1", in_ready); end
    step();
    vectors++; if (out_op1 !== 32'h33) begin miscompares++; $display("FAIL b2b first op1: got %h want 33", out_op1); end
    issue(5'd4, 5'd0, 5'd11, 1'b1, 1'b0, 32'h0, 32'h504, 8'h0); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b second in_ready: got %b want 1", in_ready); end
    step();
    vectors++; if ({out_valid, out_op1, out_rd} !== {1'b1, 32'h44, 5'd11}) begin miscompares++; $display("FAIL b2b second: got %h want %h", {out_valid, out_op1, out_rd}, {1'b1, 32'h44, 5'd11}); end
    issue(5'd11, 5'd0, 5'd12, 1'b0, 1'b0, 32'h0, 32'h508, 8'h0); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b dependent in_ready: got %b want 0", in_ready); end
    step(); exp_stall++;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b bubble: got %b want 0", out_valid); end
    idle(); step();
  endtask

  task automatic test_saturation_and_reset();
    idle();
    issue(5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 32'h0, 32'h600, 8'h0);
    step();
    out_ready = 0;
    for (int i = 0; i < 20; i++) begin
      step(); exp_stall++;
    end
    vectors++; if (stall_cycles !== sat(exp_stall)) begin miscompares++; $display("FAIL saturation: got %0d want %0d", stall_cycles, sat(exp_stall)); end
    rst = 1; #1;
    vectors++; if ({out_valid, stall_cycles} !== {1'b0, {CNT_W{1'b0}}}) begin miscompares++; $display("FAIL midop reset: got %h want 0", {out_valid, stall_cycles}); end
    step();
    rst = 0; idle(); exp_stall = 0;
    step();
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_stall = 0;
    test_reset();
    test_mem_over_wb();
    test_load_use();
    test_x0();
    test_hold_flush();
    test_wb_forward();
    test_back_to_back();
    test_saturation_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
